// File: rtl/fft_energy_writer_pkg.sv
// Shared widths, FSM state type and pipeline depth for fft_energy_writer.
package fft_energy_writer_pkg;
  localparam int DW         = 20;
  localparam int AW         = 7;
  localparam int EW         = 41;
  localparam int SQW        = 2*DW - 1;
  localparam int PIPE_DEPTH = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/fft_energy_writer_sq_pipe.sv
// energy_sq_pipe: two-stage re^2 + im^2 pipeline with valid/address sideband.
module energy_sq_pipe
  import fft_energy_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_vld,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic [AW-1:0]        in_addr,
  output logic                 pend,
  output logic                 out_vld,
  output logic [AW-1:0]        out_addr,
  output logic [EW-1:0]        out_data
);
  logic [PIPE_DEPTH:1]   vld_q;
  logic [PIPE_DEPTH:0]   vld_pipe;
  logic signed [DW-1:0]  s1_re, s1_im;
  logic signed [SQW-1:0] re_x, im_x;
  logic [AW-1:0]         s1_addr, s2_addr;
  logic [SQW-1:0]        s2_re2, s2_im2;

  assign vld_pipe = {vld_q, in_vld};
  // Squares are at most 2^38, so 39-bit wrapping products are exact.
  assign re_x = SQW'(s1_re);
  assign im_x = SQW'(s1_im);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vld_q   <= '0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_addr <= '0;
      s2_re2  <= '0;
      s2_im2  <= '0;
      s2_addr <= '0;
    end else begin
      vld_q <= vld_pipe[PIPE_DEPTH-1:0];
      if (vld_pipe[0]) begin
        s1_re   <= in_re;
        s1_im   <= in_im;
        s1_addr <= in_addr;
      end
      // Stage 2 only loads on valid so the write port holds between writes.
      if (vld_pipe[1]) begin
        s2_re2  <= re_x * re_x;
        s2_im2  <= im_x * im_x;
        s2_addr <= s1_addr;
      end
    end

  assign pend     = |vld_pipe[PIPE_DEPTH-1:1];
  assign out_vld  = vld_pipe[PIPE_DEPTH];
  assign out_addr = s2_addr;
  assign out_data = EW'(s2_re2) + EW'(s2_im2);
endmodule

// File: rtl/fft_energy_writer.sv
// Streams FFT bins through energy_sq_pipe into the energy register file, one frame per start.
// ENERGY_PINGPONG_EN: alternate frames between the low and high half of the register file.
module fft_energy_writer
  import fft_energy_writer_pkg::*;
#(
  parameter int NBINS = 64
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 fft_valid,
  output logic                 fft_ready,
  input  logic signed [DW-1:0] fft_re,
  input  logic signed [DW-1:0] fft_im,
  output logic [AW-1:0]        regffte_addr,
  output logic [EW-1:0]        regffte_in,
  output logic                 regffte_wren,
  output logic                 busy,
  output logic                 done,
  output logic                 done_bank
);
  localparam int            CW   = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBINS - 1);

  state_e        state;
  logic [CW-1:0] bin_cnt;
  logic          bank, accept, pend, drained;
  logic [AW-1:0] bin_addr;

  assign accept   = fft_valid && fft_ready;
  assign drained  = (state == DRAIN) && !pend;
  assign bin_addr = AW'(bin_cnt) | (AW'(bank) << (AW-1));

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      fft_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          fft_ready <= 1'b1;
          busy      <= 1'b1;
          bin_cnt   <= '0;
        end
        RUN: if (accept) begin
          bin_cnt <= bin_cnt + CW'(1);
          if (bin_cnt == LAST) begin
            state     <= DRAIN;
            fft_ready <= 1'b0;
          end
        end
        // Leave once stage 1 is empty: the final write is on the port this cycle.
        DRAIN: if (drained) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end

`ifdef ENERGY_PINGPONG_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bank      <= 1'b0;
      done_bank <= 1'b0;
    end else if (drained) begin
      bank      <= ~bank;
      done_bank <= bank;
    end
`else
  assign bank      = 1'b0;
  assign done_bank = 1'b0;
`endif

  energy_sq_pipe u_sq (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (accept),
    .in_re    (fft_re),
    .in_im    (fft_im),
    .in_addr  (bin_addr),
    .pend     (pend),
    .out_vld  (regffte_wren),
    .out_addr (regffte_addr),
    .out_data (regffte_in)
  );
endmodule

// File: tb/tb_fft_energy_writer.sv
// Directed bench for fft_energy_writer: reset, ramp, extremes, throttling, ping-pong, mid-frame reset.
module tb_fft_energy_writer;
  import fft_energy_writer_pkg::*;
  localparam int NB = 64;
`ifdef ENERGY_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 0, reset = 1, start = 0, fft_valid = 0;
  logic signed [DW-1:0] fft_re = '0, fft_im = '0;
  logic fft_ready, regffte_wren, busy, done, done_bank;
  logic [AW-1:0] regffte_addr;
  logic [EW-1:0] regffte_in;

  fft_energy_writer #(.NBINS(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .fft_valid(fft_valid), .fft_ready(fft_ready),
    .fft_re(fft_re), .fft_im(fft_im), .regffte_addr(regffte_addr), .regffte_in(regffte_in),
    .regffte_wren(regffte_wren), .busy(busy), .done(done), .done_bank(done_bank)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  longint re_v[NB], im_v[NB];
  bit vpat[6] = '{1, 0, 0, 1, 1, 0};
  bit mbank = 1'b0;

  int wr_addr[$], wr_cyc[$], acc_cyc[$];
  longint wr_data[$];
  int done_cnt = 0, done_cyc = 0;
  logic done_bank_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fft_valid && fft_ready) acc_cyc.push_back(cyc);
    if (regffte_wren) begin
      wr_addr.push_back(int'(regffte_addr));
      wr_data.push_back(longint'(regffte_in));
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_bank_seen = done_bank;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < NB; i++) begin
      case (kind)
        0:       begin re_v[i] = i;              im_v[i] = -i;       end
        1:       begin re_v[i] = i*1000 - 30000; im_v[i] = -(i*37);  end
        default: begin re_v[i] = i + 100;        im_v[i] = 7;        end
      endcase
    end
    if (kind == 1) begin
      re_v[0] = -524288; im_v[0] = -524288;
      re_v[1] = 524287;  im_v[1] = 0;
      re_v[2] = 0;       im_v[2] = 0;
    end
  endtask

  task automatic drive_frame(input bit throttle, input int stop_after, input bit poke_start);
    int k = 0, t = 0;
    @(posedge clk); #1 start = 1;
    @(negedge clk); chk("ready_before_start", fft_ready, 0);
    @(posedge clk); #1 start = 0;
    @(negedge clk); chk("ready_after_start", fft_ready, 1); chk("busy_run", busy, 1);
    @(posedge clk); #1;
    while (k < NB && t < 1000) begin
      fft_valid = throttle ? vpat[t % 6] : 1'b1;
      fft_re = DW'(re_v[k]);
      fft_im = DW'(im_v[k]);
      start = poke_start && (t == 20);
      @(negedge clk);
      if (fft_valid && fft_ready) k++;
      @(posedge clk); #1;
      t++;
      if (stop_after > 0 && k == stop_after) break;
    end
    fft_valid = 0;
    start = 0;
    chk("bins_accepted", (t < 1000) ? k : -1, (stop_after > 0) ? stop_after : NB);
  endtask

  task automatic check_frame(input bit exp_bank);
    int ea = 0, ed = 0, el = 0;
    chk("write_count", wr_addr.size(), NB);
    for (int i = 0; i < wr_addr.size() && i < NB; i++) begin
      if (wr_addr[i] != i + (exp_bank ? 64 : 0)) ea++;
      if (wr_data[i] != re_v[i]*re_v[i] + im_v[i]*im_v[i]) ed++;
      if (i >= acc_cyc.size() || wr_cyc[i] != acc_cyc[i] + 2) el++;
    end
    chk("addr_errors", ea, 0);
    chk("data_errors", ed, 0);
    chk("latency_errors", el, 0);
    chk("done_pulses", done_cnt, 1);
    if (wr_cyc.size() > 0) chk("done_after_last_write", done_cyc, wr_cyc[$] + 1);
    chk("done_bank", done_bank_seen, exp_bank);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic full_frame(input int kind, input bit throttle, input bit poke_start);
    fill(kind);
    clear_mon();
    drive_frame(throttle, 0, poke_start);
    @(negedge clk); chk("ready_fall", fft_ready, 0);
    repeat (10) @(negedge clk);
    check_frame(mbank);
    mbank = PP ? ~mbank : 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 0;
    #3;
    chk("rst_ready", fft_ready, 0);
    chk("rst_wren", regffte_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_bank", done_bank, 0);
    chk("rst_addr", regffte_addr, 0);
    chk("rst_data", regffte_in, 0);
    #18 reset = 1;
    repeat (3) @(negedge clk);
    chk("ready_idle", fft_ready, 0);

    // Ramp then extremes back to back: exercises bank alternation when enabled.
    full_frame(0, 1'b0, 1'b0);
    if (wr_data.size() == NB) chk("ramp_bin63", wr_data[63], 7938);
    full_frame(1, 1'b0, 1'b0);
    if (wr_data.size() >= 3) begin
      chk("ext_min", wr_data[0], 64'h0000_0080_0000_0000);
      chk("ext_max_re", wr_data[1], 64'd274876858369);
      chk("ext_zero", wr_data[2], 0);
    end

    // Throttled input with a stray start mid-frame.
    full_frame(2, 1'b1, 1'b1);

    // Reset after 10 accepted bins.
    fill(0);
    clear_mon();
    drive_frame(1'b0, 10, 1'b0);
    chk("wren_before_reset", regffte_wren, 1);
    #2 reset = 0;
    #1;
    chk("midrst_wren", regffte_wren, 0);
    chk("midrst_ready", fft_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", regffte_addr, 0);
    chk("midrst_data", regffte_in, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    mbank = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_writes", wr_addr.size(), 8);
    chk("midrst_no_done", done_cnt, 0);
    full_frame(0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
